// File: rtl/pipelined_cla_subtractor.sv
// rtl/pipelined_cla_subtractor.sv - pipelined group carry-lookahead subtractor
//
// Computes a - b - borrow_in as a + ~b + ~borrow_in, one 4-bit lookahead
// group per pipeline stage, with a global valid/ready stall.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operand beat handshake (a, b, borrow_in)
//   out_valid/out_ready      result beat handshake (diff, borrow_out, overflow)
//   diff                     (a - b - borrow_in) mod 2^WIDTH
//   borrow_out               1 when a < b + borrow_in (unsigned)
//   overflow                 signed two's-complement overflow of the subtraction

module pipelined_cla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("pipelined_cla_subtractor: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // One 4-bit lookahead group of a + ~b + cin. Returns {carry_out, sum[3:0]}.
    // Every carry is a flat sum-of-products of g/p and cin, not a ripple chain.
    function automatic logic [4:0] f_cla_group(
        input logic [3:0] i_a,
        input logic [3:0] i_b,
        input logic       i_cin
    );
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_c;
        logic       w_cout;
        w_g = i_a & ~i_b;
        w_p = i_a ^ ~i_b;
        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
        w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
        return {w_cout, w_p ^ w_c};
    endfunction

    // Stage registers. Operands travel whole with the beat so the next stage
    // can pick its group and the last stage still has the operand MSBs.
    // The group carry is stored inverted (as a borrow) so that the reset
    // value of zero gives borrow_out = 0 straight out of reset.
    logic             r_valid  [STAGES];
    logic [WIDTH-1:0] r_a      [STAGES];
    logic [WIDTH-1:0] r_b      [STAGES];
    logic [WIDTH-1:0] r_diff   [STAGES];
    logic             r_borrow [STAGES];

    logic             w_src_valid [STAGES];
    logic [WIDTH-1:0] w_src_a     [STAGES];
    logic [WIDTH-1:0] w_src_b     [STAGES];
    logic [WIDTH-1:0] w_src_diff  [STAGES];
    logic             w_src_cin   [STAGES];
    logic [4:0]       w_grp       [STAGES];
    logic [WIDTH-1:0] w_next_diff [STAGES];
    logic             w_advance;
    logic             w_unused_skew;

    // Single global stall: everything shifts together or everything holds.
    assign out_valid = r_valid[STAGES-1];
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_a[0]     = a;
        w_src_b[0]     = b;
        w_src_diff[0]  = '0;
        w_src_cin[0]   = ~borrow_in;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_a[k]     = r_a[k-1];
            w_src_b[k]     = r_b[k-1];
            w_src_diff[k]  = r_diff[k-1];
            w_src_cin[k]   = ~r_borrow[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_grp[k]       = f_cla_group(w_src_a[k][4*k +: 4], w_src_b[k][4*k +: 4], w_src_cin[k]);
            // Completed low bits ride along; this stage fills in its own group.
            w_next_diff[k] = w_src_diff[k];
            w_next_diff[k][4*k +: 4] = w_grp[k][3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]  <= 1'b0;
                r_a[k]      <= '0;
                r_b[k]      <= '0;
                r_diff[k]   <= '0;
                r_borrow[k] <= 1'b0;
            end
        end else if (w_advance) begin
            // Bubbles shift too; their data is don't-care but valid stays 0.
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]  <= w_src_valid[k];
                r_a[k]      <= w_src_a[k];
                r_b[k]      <= w_src_b[k];
                r_diff[k]   <= w_next_diff[k];
                r_borrow[k] <= ~w_grp[k][4];
            end
        end
    end

    assign diff       = r_diff[STAGES-1];
    assign borrow_out = r_borrow[STAGES-1];
    // Operands of opposite sign overflow when the result sign differs from a.
    assign overflow   = (r_a[STAGES-1][WIDTH-1] != r_b[STAGES-1][WIDTH-1])
                     && (diff[WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

    // Only the operand MSBs are read from the last stage.
    assign w_unused_skew = ^{r_a[STAGES-1][WIDTH-2:0], r_b[STAGES-1][WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// tb/tb_pipelined_cla_subtractor.sv - scoreboard bench for pipelined_cla_subtractor
module tb_pipelined_cla_subtractor;

    localparam int S16 = 4;
    localparam int S4  = 1;

    typedef struct packed {
        logic [15:0] diff;
        logic        bo;
        logic        ov;
        logic        lat;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16;
    logic [15:0] a_16, b_16, diff_16;
    logic        bin_16, bo_16, ovf_16;

    logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4;
    logic [3:0]  a_4, b_4, diff_4;
    logic        bin_4, bo_4, ovf_4;

    exp_t q16[$];
    exp_t q4[$];

    int mode16 = 0;
    int mode4  = 0;
    logic [3:0] bp_pat = 4'b1001;

    pipelined_cla_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_16), .in_ready(in_ready_16),
        .a(a_16), .b(b_16), .borrow_in(bin_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .diff(diff_16), .borrow_out(bo_16), .overflow(ovf_16)
    );

    pipelined_cla_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a_4), .b(b_4), .borrow_in(bin_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .diff(diff_4), .borrow_out(bo_4), .overflow(ovf_4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // out_ready drivers: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never, 3 = random
    initial begin
        out_ready_16 = 1'b1;
        out_ready_4  = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode16)
                1:       out_ready_16 = bp_pat[cyc % 4];
                2:       out_ready_16 = 1'b0;
                default: out_ready_16 = 1'b1;
            endcase
            out_ready_4 = (mode4 == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send16(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic ebo, input logic eov,
                          input logic lat, input logic push);
        exp_t e;
        int   t;
        @(posedge clk); #1;
        in_valid_16 = 1'b1; a_16 = va; b_16 = vb; bin_16 = vbin;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready_16) break;
            t++;
            if (t > 100) begin chk("send16_timeout", 1, 0); break; end
            @(posedge clk); #1;
        end
        if (push) begin
            e.diff = ed; e.bo = ebo; e.ov = eov; e.lat = lat; e.acc = cyc;
            q16.push_back(e);
        end
    endtask

    task automatic send4(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                         input logic [3:0] ed, input logic ebo, input logic eov, input logic lat);
        exp_t e;
        int   t;
        @(posedge clk); #1;
        in_valid_4 = 1'b1; a_4 = va; b_4 = vb; bin_4 = vbin;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready_4) break;
            t++;
            if (t > 100) begin chk("send4_timeout", 1, 0); break; end
            @(posedge clk); #1;
        end
        e.diff = {12'h000, ed}; e.bo = ebo; e.ov = eov; e.lat = lat; e.acc = cyc;
        q4.push_back(e);
    endtask

    task automatic idle16();
        @(posedge clk); #1;
        in_valid_16 = 1'b0;
    endtask

    task automatic idle4();
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
    endtask

    task automatic drain16();
        int t = 0;
        while (q16.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (q16.size() != 0) chk("drain16_pending", q16.size(), 0);
    endtask

    task automatic drain4();
        int t = 0;
        while (q4.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (q4.size() != 0) chk("drain4_pending", q4.size(), 0);
    endtask

    // Monitor for the 16-bit instance
    initial begin
        logic        hv;
        logic [17:0] hold;
        exp_t        e;
        hv = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 1'b0;
            end else begin
                chk("in_ready16", in_ready_16, !out_valid_16 || out_ready_16);
                if (out_valid_16 && hv) chk("hold16", {diff_16, bo_16, ovf_16}, hold);
                hv   = out_valid_16 && !out_ready_16;
                hold = {diff_16, bo_16, ovf_16};
                if (out_valid_16 && out_ready_16) begin
                    if (q16.size() == 0) begin
                        chk("unexpected16", 1, 0);
                    end else begin
                        e = q16.pop_front();
                        chk("diff16", diff_16, e.diff);
                        chk("borrow16", bo_16, e.bo);
                        chk("ovf16", ovf_16, e.ov);
                        if (e.lat) chk("latency16", cyc - e.acc, S16);
                    end
                end
            end
        end
    end

    // Monitor for the 4-bit instance
    initial begin
        logic       hv;
        logic [5:0] hold;
        exp_t       e;
        hv = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 1'b0;
            end else begin
                chk("in_ready4", in_ready_4, !out_valid_4 || out_ready_4);
                if (out_valid_4 && hv) chk("hold4", {diff_4, bo_4, ovf_4}, hold);
                hv   = out_valid_4 && !out_ready_4;
                hold = {diff_4, bo_4, ovf_4};
                if (out_valid_4 && out_ready_4) begin
                    if (q4.size() == 0) begin
                        chk("unexpected4", 1, 0);
                    end else begin
                        e = q4.pop_front();
                        chk("diff4", diff_4, e.diff[3:0]);
                        chk("borrow4", bo_4, e.bo);
                        chk("ovf4", ovf_4, e.ov);
                        if (e.lat) chk("latency4", cyc - e.acc, S4);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_total++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        logic [3:0] ra, rb;
        logic       rbin;
        logic [4:0] full;

        in_valid_16 = 1'b0; a_16 = '0; b_16 = '0; bin_16 = 1'b0;
        in_valid_4  = 1'b0; a_4  = '0; b_4  = '0; bin_4  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid16", out_valid_16, 0);
        chk("rst_diff16", diff_16, 0);
        chk("rst_borrow16", bo_16, 0);
        chk("rst_ovf16", ovf_16, 0);
        chk("rst_in_ready16", in_ready_16, 1);
        chk("rst_out_valid4", out_valid_4, 0);
        chk("rst_borrow4", bo_4, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single beat into an empty pipe: 4-cycle latency
        send16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1);
        idle16();
        drain16();

        // Back-to-back directed vectors
        send16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send16(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
        send16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        send16(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        send16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send16(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle16();
        drain16();

        // Back-pressure: a = i*0x1111, b = i -> diff = i*0x1110
        mode16 = 1;
        for (int i = 0; i < 8; i++)
            send16(16'(i * 16'h1111), 16'(i), 1'b0, 16'(i * 16'h1110), 1'b0, 1'b0, 1'b0, 1'b1);
        idle16();
        drain16();
        mode16 = 0;

        // Reset mid-flight with output stalled
        mode16 = 2;
        @(posedge clk);
        send16(16'hAAAA, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send16(16'h5555, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send16(16'hC3C3, 16'h0101, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle16();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid16", out_valid_16, 1);
        chk("pre_rst_diff16", diff_16, 16'h9999);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid16", out_valid_16, 0);
        chk("midrst_diff16", diff_16, 0);
        chk("midrst_in_ready16", in_ready_16, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mode16 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale16", out_valid_16, 0);
        end
        send16(16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0, 1'b1, 1'b1);
        idle16();
        drain16();

        // WIDTH=4: single stage, latency 1
        send4(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, 1'b1);
        idle4();
        drain4();

        // WIDTH=4 random sweep against an arithmetic reference
        mode4 = 3;
        for (int i = 0; i < 10000; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {4'b0000, rbin};
            send4(ra, rb, rbin, full[3:0], full[4],
                  (ra[3] != rb[3]) && (full[3] != ra[3]), 1'b0);
        end
        idle4();
        drain4();
        mode4 = 0;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_subtractor.md
Name: pipelined_cla_subtractor

Overview:
Pipelined WIDTH-bit subtractor computing A - B - borrow_in, built as the inverse of the group carry-lookahead adder. It evaluates A + ~B + ~borrow_in one 4-bit lookahead group per pipeline stage. A valid/ready handshake on both ends supports back-pressure. It sits in the arithmetic toolbox beside the CLA adder and feeds ALU/compare datapaths that need a registered difference, borrow and signed overflow.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; elaboration error otherwise
STAGES, WIDTH/4, derived localparam, not overridable; number of pipeline stages, equal to the number of 4-bit groups

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  incoming borrow (1 = subtract one more)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
diff  output  WIDTH  (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  1 when a < b + borrow_in (unsigned)
overflow  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all data registers 0. Outputs out_valid=0, diff=0, borrow_out=0, overflow=0, in_ready=1.
- Transfer rules: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Global stall:
  - advance = !out_valid || out_ready
  - in_ready = advance, combinational from out_valid/out_ready only; never from in_valid
  - On advance, every stage register loads from the preceding stage; stage 0 loads the input beat.
  - Without advance, all stages hold, including bubbles.
- Stage k (k = 0..STAGES-1) handles bits [4k+3:4k]:
  - per bit: g = a & ~b, p = a ^ ~b
  - carry in of stage 0 = ~borrow_in
  - the 4 group carries come from full lookahead equations on g/p and the group carry in (no ripple chain)
  - sum bits = p ^ carry-into-bit
  - the stage registers its 4 result bits, its group carry out, and the remaining unprocessed upper operand bits (skew registers)
- Completed low result bits travel with the beat so all WIDTH bits of diff leave together.
- Latency: exactly STAGES cycles from accepted input to out_valid, with no stalls. Throughput is one beat per cycle when out_ready is held high.
- borrow_out = ~(final group carry out).
- overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the operand MSBs carried with the beat. borrow_in does not change the formula.
- A bubble (stage valid=0) still advances on advance. Data registers in a bubble may keep stale values but out_valid=0.
- Output hold: while out_valid=1 and out_ready=0, diff/borrow_out/overflow hold stable, and in_ready=0 for that cycle.
- Simultaneous accept and consume in the same cycle is legal; the pipeline shifts and no beat is lost or duplicated.
- Reset mid-operation flushes all in-flight beats. No result is produced for them.
- WIDTH=4: single stage, latency 1.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, borrow_in=0, out_ready=1 -> after 4 cycles diff=0x1000, borrow_out=0, overflow=0.
- a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, overflow=0. Then a=0x0005, b=0x0005, borrow_in=1 -> diff=0xFFFF, borrow_out=1.
- a=0x8000, b=0x0001 -> diff=0x7FFF, overflow=1, borrow_out=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, overflow=1, borrow_out=1.
- Back-pressure: 8 back-to-back beats (a=i*0x1111, b=i) with out_ready toggling 1,0,0,1,... -> in_ready low exactly while out_valid && !out_ready; all 8 results appear in order and are correct; held output stays stable while stalled.
- Reset mid-flight: assert rst 2 cycles after 3 beats are accepted -> out_valid=0 and diff=0 immediately. No stale result appears after release; the next beat's result arrives with 4-cycle latency.
- WIDTH=4 instance: a=0x3, b=0x5, borrow_in=0 -> 1-cycle latency, diff=0xE, borrow_out=1, overflow=0; plus a random self-checking sweep of 10k beats against a reference model.
